// File: rtl/mac_vec_accum.sv
// Vector dot-product sequencer: seeds a 32-bit accumulator with a bias, adds a 4-lane
// u8 x s8 dot product per accepted beat, returns the sum. Optional clamp: MAC_ACC_SATURATE_EN.
module mac_vec_accum #(
  parameter int LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [31:0]      bias_i,
  output logic             busy_o,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [31:0]      act_i,
  input  logic [31:0]      wgt_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [31:0]      res_o,
  output logic             ovf_o
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                    state_q, state_d;
  logic signed [31:0]        acc_q, acc_d;
  logic        [LEN_W-1:0]   cnt_q, cnt_d;
  logic        [LEN_W-1:0]   len_q, len_d;
  logic                      ovf_q, ovf_d;
  logic signed [17:0]        dot_p0;
  logic        [32:0]        add_p0;
  logic                      beat_p0;

  // Activations are zero-extended, weights sign-extended; each product fits in 16 bits.
  function automatic logic signed [17:0] dot4(input logic [31:0] act, input logic [31:0] wgt);
    logic signed [17:0] a;
    logic signed [17:0] w;
    logic signed [17:0] s;
    s = '0;
    for (int k = 0; k < 4; k++) begin
      a = {10'b0, act[8*k +: 8]};
      w = {{10{wgt[8*k+7]}}, wgt[8*k +: 8]};
      s = s + a * w;
    end
    return s;
  endfunction

  // Returns {overflow, new_acc}; clamps toward the overflow direction when enabled.
  function automatic logic [32:0] acc_add(input logic signed [31:0] acc,
                                          input logic signed [17:0] dot);
    logic signed [31:0] ext;
    logic signed [31:0] sum;
    logic               ovf;
    ext = {{14{dot[17]}}, dot};
    sum = acc + ext;
    ovf = (acc[31] == ext[31]) && (sum[31] != acc[31]);
`ifdef MAC_ACC_SATURATE_EN
    if (ovf) sum = acc[31] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
`else
    sum = sum;
`endif
    return {ovf, sum};
  endfunction

  assign dot_p0  = dot4(act_i, wgt_i);
  assign add_p0  = acc_add(acc_q, dot_p0);
  assign beat_p0 = op_valid_i && (state_q == ACCUM);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          len_d   = len_i;
          acc_d   = bias_i;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = (len_i == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (beat_p0) begin
          acc_d = add_p0[31:0];
          ovf_d = ovf_q | add_p0[32];
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake outputs come straight from state so no input reaches them combinationally.
  assign busy_o      = (state_q != IDLE);
  assign op_ready_o  = (state_q == ACCUM);
  assign res_valid_o = (state_q == DONE);
  assign res_o       = acc_q;
  assign ovf_o       = ovf_q;

endmodule
